// File: rtl/apb_ucpd_cc_filter_pkg.sv
// Shared definitions for the UCPD CC debounce filter: channel FSM encoding
// and default widths.
package apb_ucpd_cc_filter_pkg;

    localparam int CNT_W_DEF = 12;
    localparam int VS_W_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_STABLE   = 2'd1,
        ST_DEBOUNCE = 2'd2
    } ch_state_e;

endpackage

// File: rtl/apb_ucpd_cc_filter_ch.sv
// One CC channel: holds a candidate level code until it has been stable for
// db_time_i prescaler ticks, then commits it and pulses an event on change.
module apb_ucpd_cc_filter_ch
    import apb_ucpd_cc_filter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int VS_W  = VS_W_DEF
) (
    input  logic             clk_d,
    input  logic             rst_d,
    input  logic             en_i,
    input  logic             tick_i,
    input  logic [CNT_W-1:0] db_time_i,
    input  logic [VS_W-1:0]  raw_i,
    output logic [VS_W-1:0]  stable_o,
    output logic             evt_o,
    output logic             busy_o
);

    ch_state_e        state_q, state_d;
    logic [VS_W-1:0]  stable_q, stable_d;
    logic [VS_W-1:0]  cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             evt_q, evt_d;
    logic             busy_q;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through this block can infer a latch.
        state_d  = state_q;
        stable_d = stable_q;
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        evt_d    = 1'b0;

        if (!en_i) begin
            state_d  = ST_IDLE;
            stable_d = '0;
            cnt_d    = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    stable_d = '0;
                    cand_d   = raw_i;
                    cnt_d    = '0;
                    state_d  = ST_DEBOUNCE;
                end
                ST_STABLE: begin
                    if (raw_i != stable_q) begin
                        cand_d  = raw_i;
                        cnt_d   = '0;
                        state_d = ST_DEBOUNCE;
                    end
                end
                ST_DEBOUNCE: begin
                    // A raw change always restarts timing, so a coincident tick is dropped.
                    if (raw_i == stable_q && raw_i != cand_q) begin
                        cnt_d   = '0;
                        state_d = ST_STABLE;
                    end else if (raw_i != cand_q) begin
                        cand_d = raw_i;
                        cnt_d  = '0;
                    end else if (cnt_q >= db_time_i) begin
                        stable_d = cand_q;
                        evt_d    = (cand_q != stable_q);
                        cnt_d    = '0;
                        state_d  = ST_STABLE;
                    end else if (tick_i && cnt_q != '1) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_d or posedge rst_d) begin
        if (rst_d) begin
            state_q  <= ST_IDLE;
            stable_q <= '0;
            cand_q   <= '0;
            cnt_q    <= '0;
            evt_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
            state_q  <= state_d;
            stable_q <= stable_d;
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            evt_q    <= evt_d;
            busy_q   <= (state_d == ST_DEBOUNCE);
        end
    end

    assign stable_o = stable_q;
    assign evt_o    = evt_q;
    assign busy_o   = busy_q;

endmodule

// File: rtl/apb_ucpd_cc_filter.sv
// UCPD CC debounce filter: two independent channel filters for CC1 and CC2
// downstream of the CC synchronizer.
module apb_ucpd_cc_filter
    import apb_ucpd_cc_filter_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int VS_W  = VS_W_DEF
) (
    input  logic             clk_d,
    input  logic             rst_d,
    input  logic [1:0]       cc_en,
    input  logic             tick,
    input  logic [CNT_W-1:0] db_time,
    input  logic [VS_W-1:0]  cc1_vs_s,
    input  logic [VS_W-1:0]  cc2_vs_s,
    output logic [VS_W-1:0]  cc1_vs,
    output logic [VS_W-1:0]  cc2_vs,
    output logic             typec_evt1,
    output logic             typec_evt2,
    output logic [1:0]       cc_busy
);

    logic busy1, busy2;

    apb_ucpd_cc_filter_ch #(
        .CNT_W (CNT_W),
        .VS_W  (VS_W)
    ) u_ch1 (
        .clk_d     (clk_d),
        .rst_d     (rst_d),
        .en_i      (cc_en[0]),
        .tick_i    (tick),
        .db_time_i (db_time),
        .raw_i     (cc1_vs_s),
        .stable_o  (cc1_vs),
        .evt_o     (typec_evt1),
        .busy_o    (busy1)
    );

    apb_ucpd_cc_filter_ch #(
        .CNT_W (CNT_W),
        .VS_W  (VS_W)
    ) u_ch2 (
        .clk_d     (clk_d),
        .rst_d     (rst_d),
        .en_i      (cc_en[1]),
        .tick_i    (tick),
        .db_time_i (db_time),
        .raw_i     (cc2_vs_s),
        .stable_o  (cc2_vs),
        .evt_o     (typec_evt2),
        .busy_o    (busy2)
    );

    assign cc_busy = {busy2, busy1};

endmodule

// File: tb/tb_apb_ucpd_cc_filter.sv
// Bench for apb_ucpd_cc_filter: run-based reference model compared every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_apb_ucpd_cc_filter;

    localparam int CNT_W = 4;
    localparam int VS_W  = 2;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic             clk_d = 1'b0;
    logic             rst_d;
    logic [1:0]       cc_en;
    logic             tick;
    logic [CNT_W-1:0] db_time;
    logic [VS_W-1:0]  cc1_vs_s, cc2_vs_s;
    logic [VS_W-1:0]  cc1_vs, cc2_vs;
    logic             typec_evt1, typec_evt2;
    logic [1:0]       cc_busy;

    int n_tests = 0;
    int n_fail  = 0;
    int evt1_cnt = 0;
    int evt2_cnt = 0;

    apb_ucpd_cc_filter #(.CNT_W(CNT_W), .VS_W(VS_W)) dut (
        .clk_d      (clk_d),
        .rst_d      (rst_d),
        .cc_en      (cc_en),
        .tick       (tick),
        .db_time    (db_time),
        .cc1_vs_s   (cc1_vs_s),
        .cc2_vs_s   (cc2_vs_s),
        .cc1_vs     (cc1_vs),
        .cc2_vs     (cc2_vs),
        .typec_evt1 (typec_evt1),
        .typec_evt2 (typec_evt2),
        .cc_busy    (cc_busy)
    );

    always #5 clk_d = ~clk_d;

    // Model view of a channel: the current run of identical raw samples,
    // whether that run still awaits its verdict, and the filtered level.
    typedef struct packed {
        logic       active;
        logic       pending;
        logic [1:0] run_v;
        logic [1:0] filt;
        logic       evt;
        int         ticks;
    } ch_model_t;

    ch_model_t m1 = '0;
    ch_model_t m2 = '0;

    function automatic ch_model_t model_next(ch_model_t c, logic en, logic [1:0] raw,
                                             logic tk, int db);
        ch_model_t n = c;
        n.evt = 1'b0;
        if (!en) begin
            n = '0;
        end else if (!c.active || raw != c.run_v) begin
            // A new run starts; it needs a verdict if freshly enabled or if it differs from the output.
            n.pending = !c.active || (raw != c.filt);
            n.active  = 1'b1;
            n.run_v   = raw;
            n.ticks   = 0;
        end else if (c.pending) begin
            if (((c.ticks > SAT) ? SAT : c.ticks) >= db) begin
                n.evt     = (c.run_v != c.filt);
                n.filt    = c.run_v;
                n.pending = 1'b0;
            end else if (tk) begin
                n.ticks = c.ticks + 1;
            end
        end
        return n;
    endfunction

    always @(posedge clk_d or posedge rst_d) begin
        if (rst_d) begin
            m1 <= '0;
            m2 <= '0;
        end else begin
            m1 <= model_next(m1, cc_en[0], cc1_vs_s, tick, int'(db_time));
            m2 <= model_next(m2, cc_en[1], cc2_vs_s, tick, int'(db_time));
        end
    end

    always @(posedge clk_d) begin
        if (typec_evt1) evt1_cnt <= evt1_cnt + 1;
        if (typec_evt2) evt2_cnt <= evt2_cnt + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    always @(negedge clk_d) begin
        check("m_cc1_vs", 32'(cc1_vs), 32'(m1.filt));
        check("m_cc2_vs", 32'(cc2_vs), 32'(m2.filt));
        check("m_evt1", 32'(typec_evt1), 32'(m1.evt));
        check("m_evt2", 32'(typec_evt2), 32'(m2.evt));
        check("m_busy", 32'(cc_busy), 32'({m2.pending, m1.pending}));
    end

    task automatic step(input logic tk);
        tick = tk;
        @(negedge clk_d);
        tick = 1'b0;
    endtask

    int e1, e2;

    initial begin
        rst_d = 1'b1; cc_en = 2'b00; tick = 1'b0; db_time = '0;
        cc1_vs_s = 2'b00; cc2_vs_s = 2'b00;
        repeat (3) @(negedge clk_d);
        rst_d = 1'b0; cc_en = 2'b11; cc1_vs_s = 2'b01; cc2_vs_s = 2'b11; db_time = 4'd1;
        for (int i = 0; i < 6; i++) step(1'b1);
        check("pre_cc2", 32'(cc2_vs), 3);

        // Reset mid-run, then enable CC1 only with db_time = 3, tick every 4 clocks.
        #2 rst_d = 1'b1;
        #1;
        check("rst_cc1", 32'(cc1_vs), 0);
        check("rst_cc2", 32'(cc2_vs), 0);
        check("rst_evt", 32'({typec_evt2, typec_evt1}), 0);
        check("rst_busy", 32'(cc_busy), 0);
        cc_en = 2'b01; db_time = 4'd3; cc1_vs_s = 2'b10; cc2_vs_s = 2'b00;
        @(negedge clk_d);
        rst_d = 1'b0;
        e1 = evt1_cnt;
        for (int i = 0; i < 12; i++) step(1'(i % 4 == 3));
        check("t1_hold", 32'(cc1_vs), 0);
        check("t1_busy", 32'(cc_busy), 1);
        step(1'b0);
        check("t1_commit", 32'(cc1_vs), 2);
        check("t1_evt", 32'(typec_evt1), 1);
        check("t1_cc2", 32'({cc2_vs, typec_evt2}), 0);
        step(1'b0);
        check("t1_evt_off", 32'(typec_evt1), 0);
        check("t1_evt_cnt", 32'(evt1_cnt - e1), 1);

        // Glitch rejection around a stable 01.
        db_time = 4'd5; cc1_vs_s = 2'b01;
        for (int i = 0; i < 8; i++) step(1'b1);
        check("t2_stable", 32'(cc1_vs), 1);
        e1 = evt1_cnt;
        cc1_vs_s = 2'b11;
        step(1'b0);
        check("t2_busy_on", 32'(cc_busy[0]), 1);
        step(1'b1); step(1'b0); step(1'b1);
        check("t2_hold", 32'(cc1_vs), 1);
        cc1_vs_s = 2'b01;
        step(1'b0);
        check("t2_busy_off", 32'(cc_busy[0]), 0);
        check("t2_level", 32'(cc1_vs), 1);
        step(1'b0);
        check("t2_no_evt", 32'(evt1_cnt - e1), 0);

        // Restart: 10 for 2 ticks, then 11 with a coincident tick that must be ignored.
        e1 = evt1_cnt;
        cc1_vs_s = 2'b10;
        step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        cc1_vs_s = 2'b11;
        step(1'b1);
        for (int i = 0; i < 5; i++) begin step(1'b0); step(1'b1); end
        check("t3_hold", 32'(cc1_vs), 1);
        step(1'b0);
        check("t3_commit", 32'(cc1_vs), 3);
        check("t3_evt", 32'(typec_evt1), 1);
        step(1'b0);
        check("t3_evt_cnt", 32'(evt1_cnt - e1), 1);

        // Zero debounce on CC2: enable with 00 (silent), then 00 -> 01 in two clocks.
        e2 = evt2_cnt;
        cc_en = 2'b11; db_time = 4'd0;
        for (int i = 0; i < 3; i++) step(1'b0);
        check("t4_en_quiet", 32'(evt2_cnt - e2), 0);
        check("t4_idle_busy", 32'(cc_busy[1]), 0);
        cc2_vs_s = 2'b01;
        step(1'b0);
        check("t4_n1", 32'(cc2_vs), 0);
        check("t4_n1_busy", 32'(cc_busy[1]), 1);
        step(1'b0);
        check("t4_n2", 32'(cc2_vs), 1);
        check("t4_evt", 32'(typec_evt2), 1);
        step(1'b0);
        check("t4_evt_cnt", 32'(evt2_cnt - e2), 1);

        // Disable CC1 mid-debounce, then re-enable with raw 00.
        db_time = 4'd5; cc1_vs_s = 2'b10;
        step(1'b0);
        check("t5_busy", 32'(cc_busy[0]), 1);
        e1 = evt1_cnt;
        cc_en = 2'b10;
        step(1'b0);
        check("t5_off_lvl", 32'(cc1_vs), 0);
        check("t5_off_busy", 32'(cc_busy[0]), 0);
        check("t5_off_evt", 32'(typec_evt1), 0);
        step(1'b0);
        cc_en = 2'b11; cc1_vs_s = 2'b00;
        for (int i = 0; i < 10; i++) step(1'b1);
        check("t5_reen_evt", 32'(evt1_cnt - e1), 0);
        check("t5_reen_lvl", 32'({cc_busy[0], cc1_vs}), 0);

        // Both channels change together, db_time = 2.
        db_time = 4'd2; cc1_vs_s = 2'b01; cc2_vs_s = 2'b10;
        step(1'b1); step(1'b1); step(1'b1);
        check("t6_hold", 32'({cc2_vs, cc1_vs}), 32'({2'b01, 2'b00}));
        step(1'b1);
        check("t6_evts", 32'({typec_evt2, typec_evt1}), 3);
        check("t6_lvls", 32'({cc2_vs, cc1_vs}), 32'({2'b10, 2'b01}));

        // Longest debounce with ticks held every clock.
        db_time = 4'd15; cc1_vs_s = 2'b11;
        step(1'b0);
        e1 = evt1_cnt;
        for (int i = 0; i < 15; i++) step(1'b1);
        check("t6_sat_hold", 32'(cc1_vs), 1);
        for (int i = 0; i < 5; i++) step(1'b1);
        check("t6_sat_lvl", 32'(cc1_vs), 3);
        check("t6_sat_once", 32'(evt1_cnt - e1), 1);

        // Randomized traffic against the model.
        cc_en = 2'b11; db_time = 4'd2;
        for (int i = 0; i < 5000; i++) begin
            if ($urandom_range(0, 11) == 0) cc1_vs_s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 11) == 0) cc2_vs_s = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 299) == 0) cc_en = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 149) == 0) cc_en = 2'b11;
            if ($urandom_range(0, 99) == 0)
                db_time = ($urandom_range(0, 4) == 0) ? 4'd15 : CNT_W'($urandom_range(0, 4));
            tick = 1'($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 1499) == 0) begin
                #2 rst_d = 1'b1;
                @(negedge clk_d);
                rst_d = 1'b0;
            end
            @(negedge clk_d);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
